// File: rtl/entropy_collector_if.sv
// Word handshake (data/valid/ack) between entropy source, collector and mixer.
// The master drives data and valid; the slave answers with ack.
interface entropy_collector_if;
  logic [31:0] data;
  logic        valid;
  logic        ack;

  modport master (output data, output valid, input ack);
  modport slave  (input data, input valid, output ack);
endinterface

// File: rtl/entropy_collector.sv
// Entropy collector: accepts words from an entropy source (at most one every
// three cycles) into a small FIFO that feeds the mixer.
// Optional feature macro: STUCK_CHECK_EN enables the repetition (stuck source)
// check that discards the REP_LIMIT-th identical word and raises a sticky
// security_error.
module entropy_collector #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned REP_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  entropy_enabled,
  entropy_collector_if.slave    entropy,
  entropy_collector_if.master   collected,
  output logic [4:0]            fill_level,
  output logic                  security_error
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW = 5;

  // Parameter sanity at elaboration time
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("entropy_collector: DEPTH must be a power of two in 2..16");
  end
  if (REP_LIMIT < 1) begin : g_bad_rep_limit
    $error("entropy_collector: REP_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACK, COOL} state_t;

  state_t          state_q, state_d;
  logic [31:0]     word_q;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]   fill_q;
  logic            accept_c;
  logic            push_c;
  logic            pop_c;
  logic            discard_c;

`ifdef STUCK_CHECK_EN
  localparam int unsigned CW = $clog2(REP_LIMIT + 1);

  logic [31:0]   prev_q;
  logic [CW-1:0] rep_cnt_q;
  logic [CW-1:0] rep_cnt_next_c;
  logic          sec_err_q;

  // Run length of the word currently in ACK; the limit-th repeat is dropped
  always_comb begin
    rep_cnt_next_c = CW'(1);
    if (rep_cnt_q != '0 && word_q == prev_q) begin
      rep_cnt_next_c = rep_cnt_q + CW'(1);
    end
    discard_c = (rep_cnt_next_c == CW'(REP_LIMIT));
  end

  // Repetition history and sticky error; cleared by reset or enable low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      rep_cnt_q <= '0;
      sec_err_q <= 1'b0;
    end else if (!enable) begin
      prev_q    <= '0;
      rep_cnt_q <= '0;
      sec_err_q <= 1'b0;
    end else if (state_q == ACK) begin
      prev_q    <= word_q;
      rep_cnt_q <= rep_cnt_next_c;
      if (discard_c) begin
        sec_err_q <= 1'b1;
      end
    end
  end

  assign security_error = sec_err_q;
`else
  assign discard_c      = 1'b0;
  assign security_error = 1'b0;
`endif

  assign accept_c = (state_q == IDLE) && enable && entropy_enabled && entropy.valid &&
                    (fill_q < FW'(DEPTH)) && !security_error;
  assign push_c   = (state_q == ACK) && enable && !discard_c;
  assign pop_c    = collected.valid && collected.ack;

  assign entropy.ack     = (state_q == ACK);
  assign collected.valid = (fill_q != '0);
  assign collected.data  = collected.valid ? mem[rd_ptr_q] : 32'h0;
  assign fill_level      = fill_q;

  // Input FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Input FSM next state: accept, one ACK cycle, one cool-down cycle
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept_c) state_d = ACK;
        ACK:     state_d = COOL;
        COOL:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Capture the source word on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else if (accept_c) begin
      word_q <= entropy.data;
    end
  end

  // FIFO storage; contents are only visible through valid pointers
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= word_q;
    end
  end

  // FIFO pointers and occupancy; enable low flushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (!enable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector with a scoreboard queue of expected
// mixer words and an independent monitor that checks every pop.
module tb_entropy_collector;

  logic clk;
  logic reset;
  logic enable;
  logic entropy_enabled;
  logic [4:0] fill_level;
  logic security_error;

  entropy_collector_if src_if ();
  entropy_collector_if col_if ();

  entropy_collector #(.DEPTH(8), .REP_LIMIT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .entropy_enabled (entropy_enabled),
    .entropy         (src_if),
    .collected       (col_if),
    .fill_level      (fill_level),
    .security_error  (security_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];
  int max_fill = 0;
  int words_sent = 0;
  bit src_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every word the mixer takes must be the next expected word
  always @(negedge clk) begin
    if (32'(fill_level) > max_fill) max_fill = 32'(fill_level);
    if (col_if.valid === 1'b1 && col_if.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", col_if.data, 32'hDEAD_BEEF);
      end else begin
        check("pop_data", col_if.data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and wait (bounded) for its ack; returns at that negedge
  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (src_if.ack !== 1'b1 && n < 300);
    check(name, 32'(src_if.ack), 32'h1);
  endtask

  task automatic send_word(input logic [31:0] w);
    src_if.data  = w;
    src_if.valid = 1'b1;
    wait_ack("src_ack");
    tick();
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (col_if.valid === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(col_if.valid), 32'h0);
  endtask

  initial begin
    int n_ack;
    int last;
    int exp_acks;
    int exp_fill;
    logic exp_sec;

    reset           = 1'b1;
    enable          = 1'b0;
    entropy_enabled = 1'b0;
    src_if.data     = '0;
    src_if.valid    = 1'b0;
    col_if.ack      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_fill", 32'(fill_level), 32'h0);
    check("rst_valid", 32'(col_if.valid), 32'h0);
    check("rst_data", col_if.data, 32'h0);
    check("rst_ack", 32'(src_if.ack), 32'h0);
    check("rst_sec", 32'(security_error), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Constant source, no draining
`ifdef STUCK_CHECK_EN
    exp_acks = 4;
    exp_fill = 3;
    exp_sec  = 1'b1;
`else
    exp_acks = 8;
    exp_fill = 8;
    exp_sec  = 1'b0;
`endif
    enable          = 1'b1;
    entropy_enabled = 1'b1;
    src_if.data     = 32'h1122_3344;
    src_if.valid    = 1'b1;
    n_ack = 0;
    last  = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (src_if.ack === 1'b1) begin
        if (n_ack > 0) check("ack_spacing", 32'(c - last), 32'd3);
        last = c;
        n_ack++;
      end
    end
    check("const_acks", 32'(n_ack), 32'(exp_acks));
    check("const_fill", 32'(fill_level), 32'(exp_fill));
    check("const_sec", 32'(security_error), 32'(exp_sec));
    tick();
    src_if.valid = 1'b0;
    for (int i = 0; i < exp_fill; i++) exp_q.push_back(32'h1122_3344);
    col_if.ack = 1'b1;
    wait_empty("const_drain");
    col_if.ack = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    @(negedge clk);
    check("sec_cleared", 32'(security_error), 32'h0);
    tick();

    // Incrementing source into a full FIFO, then drained while refilling
    for (int w = 1; w <= 12; w++) exp_q.push_back(32'(w));
    max_fill = 0;
    fork
      begin
        for (int w = 1; w <= 12; w++) begin
          send_word(32'(w));
          words_sent++;
        end
        src_if.valid = 1'b0;
        src_done = 1;
      end
    join_none
    repeat (40) @(negedge clk);
    check("full_sent", 32'(words_sent), 32'd8);
    check("full_fill", 32'(fill_level), 32'd8);
    check("full_no_ack", 32'(src_if.ack), 32'h0);
    tick();
    col_if.ack = 1'b1;
    for (int n = 0; n < 300 && !src_done; n++) @(negedge clk);
    check("inc_src_done", 32'(src_done), 32'h1);
    wait_empty("inc_drain");
    col_if.ack = 1'b0;
    check("inc_all_popped", 32'(exp_q.size()), 32'h0);
    check("inc_max_fill", 32'(max_fill), 32'd8);
    tick();

    // Enable dropped during an ACK with five words stored
    for (int w = 101; w <= 105; w++) send_word(32'(w));
    src_if.data = 32'd106;
    wait_ack("ack_106");
    check("abort_pre_fill", 32'(fill_level), 32'd5);
    enable       = 1'b0;
    src_if.valid = 1'b0;
    @(negedge clk);
    check("abort_fill", 32'(fill_level), 32'h0);
    check("abort_valid", 32'(col_if.valid), 32'h0);
    check("abort_data", col_if.data, 32'h0);
    check("abort_ack", 32'(src_if.ack), 32'h0);
    check("abort_sec", 32'(security_error), 32'h0);
    tick();
    enable = 1'b1;
    exp_q.push_back(32'd200);
    send_word(32'd200);
    src_if.valid = 1'b0;
    col_if.ack = 1'b1;
    wait_empty("abort_drain");
    col_if.ack = 1'b0;
    tick();

    // Asynchronous reset mid-ACK with two words stored
    send_word(32'd301);
    send_word(32'd302);
    src_if.data = 32'd303;
    wait_ack("ack_303");
    check("rst2_pre_fill", 32'(fill_level), 32'd2);
    #1;
    reset        = 1'b1;
    src_if.valid = 1'b0;
    #1;
    check("rst2_fill", 32'(fill_level), 32'h0);
    check("rst2_valid", 32'(col_if.valid), 32'h0);
    check("rst2_data", col_if.data, 32'h0);
    check("rst2_ack", 32'(src_if.ack), 32'h0);
    check("rst2_sec", 32'(security_error), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Source not running: no accepts
    entropy_enabled = 1'b0;
    src_if.data     = 32'd999;
    src_if.valid    = 1'b1;
    n_ack = 0;
    repeat (8) begin
      @(negedge clk);
      if (src_if.ack === 1'b1) n_ack++;
    end
    check("src_disabled_acks", 32'(n_ack), 32'h0);
    tick();
    src_if.valid    = 1'b0;
    entropy_enabled = 1'b1;
    exp_q.push_back(32'd400);
    send_word(32'd400);
    src_if.valid = 1'b0;
    col_if.ack = 1'b1;
    wait_empty("final_drain");
    col_if.ack = 1'b0;
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/entropy_collector.md
ENTROPY_COLLECTOR -- requirements
Module: entropy_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of two, 2..16).
REQ-002 SHALL have parameter REP_LIMIT, default 4, number of consecutive identical accepted words that trips the stuck check.
REQ-003 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  collector enable.
REQ-006 entropy_enabled  in  1  source reports it is running.
REQ-007 entropy_data  in  32  word from the upstream entropy source.
REQ-008 entropy_valid  in  1  entropy_data holds a word.
REQ-009 entropy_ack  out  1  one-cycle pulse, word consumed.
REQ-010 collected_data  out  32  FIFO head word to the mixer.
REQ-011 collected_valid  out  1  FIFO not empty.
REQ-012 collected_ack  in  1  mixer takes the head word.
REQ-013 fill_level  out  5  current FIFO occupancy, 0..DEPTH.
REQ-014 security_error  out  1  sticky stuck-source flag.

Function
REQ-015 Input FSM states: IDLE, ACK, COOL; IDLE->ACK when enable & entropy_enabled & entropy_valid & fill_level<DEPTH & !security_error, sampled on a clock edge.
REQ-016 On the IDLE->ACK edge the word SHALL be registered; in ACK entropy_ack=1 for exactly one cycle and the word is written to FIFO (unless discarded per REQ-026).
REQ-017 ACK->COOL unconditionally; COOL->IDLE unconditionally; minimum spacing between accepts is 3 cycles, so a constantly valid source yields one word per 3 cycles.
REQ-018 FIFO full (fill_level==DEPTH) SHALL block IDLE->ACK; the pending source word remains un-acked.
REQ-019 collected_valid = (fill_level!=0); collected_data = head word, 32'h0 when empty.
REQ-020 Pop on collected_valid & collected_ack; collected_ack while empty SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave fill_level unchanged and preserve order; full decision for REQ-018 uses registered fill_level (pop in same cycle does not admit a push).
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; no overflow or underflow under any stimulus.
REQ-023 enable low SHALL, on the next edge, return FSM to IDLE, clear FIFO (fill_level=0), clear repetition state and security_error; an ACK cycle in progress is aborted (entropy_ack drops, word not written).
REQ-024 entropy_enabled low SHALL only block new accepts; FIFO contents remain drainable.

Reset
REQ-025 Asserting reset SHALL immediately force: FSM=IDLE, entropy_ack=0, fill_level=0, collected_valid=0, collected_data=32'h0, security_error=0, pointers and repetition counter=0; mid-transfer words are lost.

Configuration
REQ-026 With STUCK_CHECK_EN defined: each accepted word is compared to previous accepted word; counter=1 on first/different word, +1 on identical; when counter reaches REP_LIMIT, that word is discarded (still acked), security_error sets sticky and further accepts stop until enable low or reset.
REQ-027 Without STUCK_CHECK_EN: no comparator/counter, security_error tied 0, every accepted word written.

Verification
REQ-028 Constant source 32'h11223344, valid=1, enable=1, collected_ack=0, STUCK_CHECK_EN on -> 3 words stored, 4th acked and discarded, security_error=1, fill_level=3, no further entropy_ack.
REQ-029 Same stimulus, STUCK_CHECK_EN off -> entropy_ack every 3rd cycle, fill_level reaches 8, then entropy_ack stays 0; security_error=0.
REQ-030 Incrementing source 1,2,3..., FIFO full, collected_ack held 1 -> drained in order 1..8, then word 9 accepted; fill_level never exceeds 8.
REQ-031 enable dropped for one cycle during ACK with fill_level=5 -> next cycle fill_level=0, collected_valid=0, security_error=0, FSM IDLE.
REQ-032 reset asserted asynchronously mid-ACK with fill_level=2 -> outputs reach REQ-025 values before next clk edge.
